// File: rtl/rv_gpr_wb_arb_pkg.sv
// Shared types and widths for the GPR writeback arbiter and scoreboard.
package rv_gpr_wb_arb_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned GPR_ADDR_W = 5;
    localparam int unsigned NUM_GPR    = 32;

    // Which source owns the write port in a given cycle
    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_LSU,
        WB_MDU
    } wb_src_e;

    // Result payload offered by an execution unit
    typedef struct packed {
        logic                  valid;
        logic [GPR_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    // One-hot decode of a register index
    function automatic logic [NUM_GPR-1:0] rd_onehot(input logic [GPR_ADDR_W-1:0] rd);
        return NUM_GPR'(1) << rd;
    endfunction

endpackage

// File: rtl/rv_gpr_wb_arb_if.sv
// Result buses from ALU/LSU/MDU into the writeback arbiter.
interface rv_gpr_wb_arb_if;
    import rv_gpr_wb_arb_pkg::*;

    wb_req_t alu;
    wb_req_t lsu;
    logic    lsu_ready;
    wb_req_t mdu;
    logic    mdu_ready;

    // Execution units drive results and observe acceptance
    modport master (
        output alu, lsu, mdu,
        input  lsu_ready, mdu_ready
    );

    // Arbiter consumes results and returns acceptance
    modport slave (
        input  alu, lsu, mdu,
        output lsu_ready, mdu_ready
    );

endinterface

// File: rtl/rv_gpr_wb_arb_rr.sv
// Two-way arbiter between LSU (req[0]) and MDU (req[1]) long-latency results.
module rv_gpr_wb_arb_rr #(
    parameter bit RR_EN = 1'b1
) (
    input  logic       clk_i,
    input  logic       arstn_i,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] gnt_c
);

    // 0: LSU served last, 1: MDU served last
    logic last_q;

    // Grant the requester that was not served last, or LSU under fixed priority
    always_comb begin
        gnt_c = 2'b00;
        if (req == 2'b11) begin
            if (RR_EN) begin
                gnt_c = last_q ? 2'b01 : 2'b10;
            end else begin
                gnt_c = 2'b01;
            end
        end else begin
            gnt_c = req;
        end
    end

    // Remember who was served; moves only on an accepted long result
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            last_q <= 1'b1;
        end else if (adv) begin
            last_q <= gnt_c[1];
        end
    end

endmodule

// File: rtl/rv_gpr_wb_arb.sv
// Writeback arbiter for the single GPR write port plus busy scoreboard for long ops.
module rv_gpr_wb_arb
    import rv_gpr_wb_arb_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  arstn_i,
    input  logic                  iss_valid_i,
    input  logic [GPR_ADDR_W-1:0] iss_rd_i,
    input  logic [GPR_ADDR_W-1:0] q1_addr_i,
    input  logic [GPR_ADDR_W-1:0] q2_addr_i,
    input  logic [GPR_ADDR_W-1:0] qd_addr_i,
    output logic                  q1_busy_o,
    output logic                  q2_busy_o,
    output logic                  qd_busy_o,
    rv_gpr_wb_arb_if.slave        wb,
    output logic                  wr_en_o,
    output logic [GPR_ADDR_W-1:0] wr_addr_o,
    output logic [XLEN-1:0]       wr_data_o
);

    logic [1:0]         long_req;
    logic [1:0]         long_gnt;
    wb_src_e            win_src;
    wb_req_t            win;
    logic               wr_long_q;
    logic [NUM_GPR-1:0] busy_q;
    logic [NUM_GPR-1:0] busy_set;
    logic [NUM_GPR-1:0] busy_clr;

    // ALU has no backpressure, so long results only compete when the ALU is idle
    assign long_req = {wb.mdu.valid, wb.lsu.valid} & {2{~wb.alu.valid}};

    rv_gpr_wb_arb_rr #(
        .RR_EN (RR_EN)
    ) u_rr (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .req     (long_req),
        .adv     (|long_gnt),
        .gnt_c   (long_gnt)
    );

    assign wb.lsu_ready = long_gnt[0];
    assign wb.mdu_ready = long_gnt[1];

    // Select the winning result for this cycle
    always_comb begin
        win_src = WB_NONE;
        win     = '0;
        if (wb.alu.valid) begin
            win_src = WB_ALU;
            win     = wb.alu;
        end else if (long_gnt[0]) begin
            win_src = WB_LSU;
            win     = wb.lsu;
        end else if (long_gnt[1]) begin
            win_src = WB_MDU;
            win     = wb.mdu;
        end
    end

    // Register the winner; x0 results are consumed without a write and address/data hold
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            wr_en_o   <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
            wr_long_q <= 1'b0;
        end else begin
            wr_en_o   <= win.valid && (win.rd != '0);
            wr_long_q <= ((win_src == WB_LSU) || (win_src == WB_MDU)) && (win.rd != '0);
            if (win.valid && (win.rd != '0)) begin
                wr_addr_o <= win.rd;
                wr_data_o <= win.data;
            end
        end
    end

    // Set on issue of a long op, clear once its GPR write is on the port
    always_comb begin
        busy_set = (iss_valid_i && (iss_rd_i != '0)) ? rd_onehot(iss_rd_i) : '0;
        busy_clr = (wr_en_o && wr_long_q) ? rd_onehot(wr_addr_o) : '0;
    end

    // Scoreboard update; set wins over clear and x0 is never busy
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= ((busy_q & ~busy_clr) | busy_set) & ~NUM_GPR'(1);
        end
    end

    assign q1_busy_o = busy_q[q1_addr_i];
    assign q2_busy_o = busy_q[q2_addr_i];
    assign qd_busy_o = busy_q[qd_addr_i];

    // Decode must stall rather than issue a second long op to a pending rd
    a_iss_not_busy : assert property (
        @(posedge clk_i) disable iff (!arstn_i)
        (iss_valid_i && (iss_rd_i != '0)) |-> !busy_q[iss_rd_i]
    );

endmodule

// File: tb/tb_rv_gpr_wb_arb.sv
// Directed + randomized bench for rv_gpr_wb_arb against a behavioural model.
module tb_rv_gpr_wb_arb;
    import rv_gpr_wb_arb_pkg::*;

    localparam int G_NONE = 0;
    localparam int G_ALU  = 1;
    localparam int G_LSU  = 2;
    localparam int G_MDU  = 3;

    logic        clk_i = 1'b0;
    logic        arstn_i;
    logic        iss_valid;
    logic [4:0]  iss_rd, q1, q2, qd;
    logic        q1_busy, q2_busy, qd_busy;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        d0_q1, d0_q2, d0_qd, d0_wr_en;
    logic [4:0]  d0_wr_addr;
    logic [31:0] d0_wr_data;

    int errors = 0;
    int checks = 0;

    // Model state
    bit        m_busy [32];
    bit        m_wr_en;
    bit [4:0]  m_wr_addr;
    bit [31:0] m_wr_data;
    bit        m_wr_long;
    int        m_last;
    int        last_g;

    always #5 clk_i = ~clk_i;

    rv_gpr_wb_arb_if bus ();
    rv_gpr_wb_arb_if bus0 ();

    assign bus0.alu = bus.alu;
    assign bus0.lsu = bus.lsu;
    assign bus0.mdu = bus.mdu;

    rv_gpr_wb_arb #(.RR_EN(1'b1)) dut (
        .clk_i(clk_i), .arstn_i(arstn_i), .iss_valid_i(iss_valid), .iss_rd_i(iss_rd),
        .q1_addr_i(q1), .q2_addr_i(q2), .qd_addr_i(qd),
        .q1_busy_o(q1_busy), .q2_busy_o(q2_busy), .qd_busy_o(qd_busy),
        .wb(bus), .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data)
    );

    // Fixed-priority variant: never issues long ops, only observed for arbitration order
    rv_gpr_wb_arb #(.RR_EN(1'b0)) dut0 (
        .clk_i(clk_i), .arstn_i(arstn_i), .iss_valid_i(1'b0), .iss_rd_i(5'd0),
        .q1_addr_i(q1), .q2_addr_i(q2), .qd_addr_i(qd),
        .q1_busy_o(d0_q1), .q2_busy_o(d0_q2), .qd_busy_o(d0_qd),
        .wb(bus0), .wr_en_o(d0_wr_en), .wr_addr_o(d0_wr_addr), .wr_data_o(d0_wr_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Who may write this cycle, from the arbitration rules
    function automatic int model_grant();
        if (bus.alu.valid) return G_ALU;
        if (bus.lsu.valid && bus.mdu.valid) return (m_last == G_LSU) ? G_MDU : G_LSU;
        if (bus.lsu.valid) return G_LSU;
        if (bus.mdu.valid) return G_MDU;
        return G_NONE;
    endfunction

    task automatic model_reset();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_wr_en   = 1'b0;
        m_wr_addr = '0;
        m_wr_data = '0;
        m_wr_long = 1'b0;
        m_last    = G_MDU;
        last_g    = G_NONE;
    endtask

    task automatic check_comb();
        int g;
        g = model_grant();
        chk("lsu_ready", bus.lsu_ready, (g == G_LSU));
        chk("mdu_ready", bus.mdu_ready, (g == G_MDU));
        chk("q1_busy", q1_busy, m_busy[q1]);
        chk("q2_busy", q2_busy, m_busy[q2]);
        chk("qd_busy", qd_busy, m_busy[qd]);
    endtask

    // Advance one clock: predict from current inputs, then compare registered outputs
    task automatic tick();
        int        g;
        bit [4:0]  rd;
        bit [31:0] d;
        bit        clr_en, iv;
        bit [4:0]  clr_a, ir;
        g = model_grant();
        rd = '0;
        d  = '0;
        case (g)
            G_ALU: begin rd = bus.alu.rd; d = bus.alu.data; end
            G_LSU: begin rd = bus.lsu.rd; d = bus.lsu.data; end
            G_MDU: begin rd = bus.mdu.rd; d = bus.mdu.data; end
            default: ;
        endcase
        clr_en = m_wr_en && m_wr_long;
        clr_a  = m_wr_addr;
        iv     = iss_valid;
        ir     = iss_rd;
        @(posedge clk_i);
        if (clr_en) m_busy[clr_a] = 1'b0;
        if (iv && ir != 0) m_busy[ir] = 1'b1;
        m_wr_en = (g != G_NONE) && (rd != 0);
        m_wr_long = (g == G_LSU || g == G_MDU) && (rd != 0);
        if (m_wr_en) begin
            m_wr_addr = rd;
            m_wr_data = d;
        end
        if (g == G_LSU || g == G_MDU) m_last = g;
        last_g = g;
        #1;
        chk("wr_en", wr_en, m_wr_en);
        chk("wr_addr", wr_addr, m_wr_addr);
        chk("wr_data", wr_data, m_wr_data);
    endtask

    initial begin
        bit        exp_lsu;
        bit [31:0] data_b;
        arstn_i   = 1'b0;
        iss_valid = 1'b0;
        iss_rd    = '0;
        q1 = 5'd3; q2 = 5'd7; qd = 5'd9;
        bus.alu = '0;
        bus.lsu = '0;
        bus.mdu = '0;
        model_reset();
        #2;
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_wr_addr", wr_addr, 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_q1_busy", q1_busy, 1'b0);
        @(negedge clk_i);
        arstn_i = 1'b1;

        // ALU result appears on the write port one edge later
        bus.alu = '{1'b1, 5'd5, 32'h12345678};
        #1 check_comb();
        tick();
        chk("alu_wr_en", wr_en, 1'b1);
        chk("alu_wr_addr", wr_addr, 32'd5);
        chk("alu_wr_data", wr_data, 32'h12345678);
        bus.alu.valid = 1'b0;
        tick();

        // Long op on x7: busy until the cycle after its write
        iss_valid = 1'b1; iss_rd = 5'd7;
        tick();
        iss_valid = 1'b0;
        q1 = 5'd7;
        #1 chk("iss7_busy", q1_busy, 1'b1);
        bus.mdu = '{1'b1, 5'd7, 32'h0000DEAD};
        #1 chk("mdu_ready7", bus.mdu_ready, 1'b1);
        tick();
        chk("mdu_wr_en", wr_en, 1'b1);
        chk("mdu_wr_data", wr_data, 32'h0000DEAD);
        bus.mdu.valid = 1'b0;
        #1 chk("busy_hold_at_write", q1_busy, 1'b1);
        tick();
        chk("busy_clear_after", q1_busy, 1'b0);

        // LSU and MDU contend: alternate, LSU first; fixed priority always LSU
        bus.lsu = '{1'b1, 5'd10, 32'hA0A0_0000};
        bus.mdu = '{1'b1, 5'd11, 32'hB0B0_0000};
        for (int i = 0; i < 4; i++) begin
            exp_lsu = (i % 2) == 0;
            #1;
            chk("rr_lsu_ready", bus.lsu_ready, exp_lsu);
            chk("rr_mdu_ready", bus.mdu_ready, !exp_lsu);
            chk("fixed_lsu_ready", bus0.lsu_ready, 1'b1);
            tick();
            chk("rr_wr_addr", wr_addr, exp_lsu ? 32'd10 : 32'd11);
            if (i == 0) begin
                chk("fixed_wr_en", d0_wr_en, 1'b1);
                chk("fixed_wr_addr", d0_wr_addr, 32'd10);
                chk("fixed_wr_data", d0_wr_data, 32'hA0A0_0000);
            end
            if (exp_lsu) bus.lsu.data = $urandom;
            else         bus.mdu.data = $urandom;
        end
        bus.lsu.valid = 1'b0;
        bus.mdu.valid = 1'b0;

        // ALU beats LSU; LSU waits with its data held
        data_b  = 32'hBEEF_0009;
        bus.alu = '{1'b1, 5'd8, 32'hCAFE_0008};
        bus.lsu = '{1'b1, 5'd9, data_b};
        #1 chk("alu_blocks_lsu", bus.lsu_ready, 1'b0);
        tick();
        chk("alu_first_addr", wr_addr, 32'd8);
        bus.alu.valid = 1'b0;
        #1 chk("lsu_after_alu_ready", bus.lsu_ready, 1'b1);
        tick();
        chk("lsu_late_addr", wr_addr, 32'd9);
        chk("lsu_late_data", wr_data, data_b);
        bus.lsu.valid = 1'b0;

        // Long result to x0: accepted, no write, scoreboard untouched
        bus.lsu = '{1'b1, 5'd0, 32'h0000FFFF};
        #1 chk("x0_lsu_ready", bus.lsu_ready, 1'b1);
        tick();
        chk("x0_no_write", wr_en, 1'b0);
        chk("x0_hold_addr", wr_addr, 32'd9);
        chk("x0_hold_data", wr_data, data_b);
        bus.lsu.valid = 1'b0;
        for (int r = 0; r < 32; r++) begin
            q1 = 5'(r);
            #0.1;
            chk("x0_busy_vec", q1_busy, m_busy[r]);
        end

        // Reset in the middle of a pending long op and a pending write
        iss_valid = 1'b1; iss_rd = 5'd3;
        tick();
        iss_valid = 1'b0;
        q1 = 5'd3;
        #1 chk("iss3_busy", q1_busy, 1'b1);
        bus.alu = '{1'b1, 5'd12, 32'h1234_000C};
        tick();
        bus.alu.valid = 1'b0;
        arstn_i = 1'b0;
        model_reset();
        #1;
        chk("midrst_wr_en", wr_en, 1'b0);
        chk("midrst_busy3", q1_busy, 1'b0);
        chk("midrst_wr_addr", wr_addr, 32'd0);
        @(negedge clk_i);
        arstn_i = 1'b1;
        tick();
        chk("post_rst_no_write", wr_en, 1'b0);

        // Randomized traffic
        for (int cyc = 0; cyc < 400; cyc++) begin
            bus.alu.valid = ($urandom_range(0, 3) == 0);
            bus.alu.rd    = 5'($urandom_range(0, 31));
            bus.alu.data  = $urandom;
            if (!bus.lsu.valid || last_g == G_LSU) begin
                bus.lsu.valid = 1'($urandom_range(0, 1));
                bus.lsu.rd    = 5'($urandom_range(0, 31));
                bus.lsu.data  = $urandom;
            end
            if (!bus.mdu.valid || last_g == G_MDU) begin
                bus.mdu.valid = 1'($urandom_range(0, 1));
                bus.mdu.rd    = 5'($urandom_range(0, 31));
                bus.mdu.data  = $urandom;
            end
            iss_rd    = 5'($urandom_range(0, 31));
            iss_valid = ($urandom_range(0, 2) == 0) && !m_busy[iss_rd];
            q1 = 5'($urandom_range(0, 31));
            q2 = 5'($urandom_range(0, 31));
            qd = 5'($urandom_range(0, 31));
            #1 check_comb();
            tick();
        end

        chk("fixed_never_busy", {31'd0, d0_q1 | d0_q2 | d0_qd}, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
